// File: rtl/kpyd_pkg.sv
// ============================================================================
//  Module      : kpyd_pkg
//  Description : Shared types and helpers for the 4x4 keypad scanner and the
//                keypad-to-hex LUT translator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kpyd_pkg;

    localparam int unsigned KPYD_ROWS   = 4;
    localparam int unsigned KPYD_COLS   = 4;
    localparam int unsigned KPYD_CODE_W = KPYD_ROWS + KPYD_COLS;

    typedef logic [KPYD_ROWS-1:0]   kpyd_row_t;
    typedef logic [KPYD_COLS-1:0]   kpyd_col_t;
    typedef logic [KPYD_CODE_W-1:0] kpyd_code_t;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2
    } kpyd_state_e;

    function automatic kpyd_row_t kpyd_rot_row(input kpyd_row_t r);
        return {r[KPYD_ROWS-2:0], r[KPYD_ROWS-1]};
    endfunction

    function automatic logic kpyd_is_onehot(input kpyd_col_t c);
        return (c != '0) && ((c & (c - 1'b1)) == '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/kpyd_sync.sv
// ============================================================================
//  Module      : kpyd_sync
//  Description : Parameterised-width two-flop synchronizer, reset to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kpyd_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/kpyd_scanner.sv
// ============================================================================
//  Module      : kpyd_scanner
//  Description : 4x4 keypad row scanner with debounce and valid/ready output.
//                Optional auto-repeat when KPYD_SCANNER_REPEAT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kpyd_scanner
    import kpyd_pkg::*;
#(
    parameter int unsigned scan_cycles_p = 1000,
    parameter int unsigned debounce_p    = 4,
    parameter int unsigned repeat_p      = 250
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [KPYD_COLS-1:0]   col_i,
    output logic [KPYD_ROWS-1:0]   row_o,
    output logic [KPYD_CODE_W-1:0] kpyd_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   pressed_o
);

    localparam int unsigned CW = (scan_cycles_p > 1) ? $clog2(scan_cycles_p) : 1;
    localparam int unsigned MW = $clog2(debounce_p + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(scan_cycles_p - 1);
    localparam logic [MW-1:0] DEB_N      = MW'(debounce_p);

    if (scan_cycles_p < 3 || debounce_p == 0 || repeat_p == 0) begin : g_param_check
        $error("kpyd_scanner: parameter out of range");
    end

    kpyd_col_t   w_cs;
    logic        w_sample;
    logic        w_hit;
    logic        w_match;

    logic [CW-1:0] dwell_q, dwell_d;
    kpyd_state_e   state_q;
    kpyd_row_t     row_q;
    kpyd_col_t     col_q;
    kpyd_code_t    kpyd_q;
    logic          valid_q;
    logic          pressed_q;
    logic [MW-1:0] match_q;
    logic [MW-1:0] rel_q;

`ifdef KPYD_SCANNER_REPEAT_EN
    localparam int unsigned RW = $clog2(repeat_p + 1);
    localparam logic [RW-1:0] REP_N = RW'(repeat_p);
    logic [RW-1:0] rep_q;
`endif

    kpyd_sync #(
        .WIDTH (KPYD_COLS)
    ) u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (col_i),
        .q_o     (w_cs)
    );

    assign w_sample = (dwell_q == DWELL_LAST);
    assign w_hit    = kpyd_is_onehot(w_cs);
    assign w_match  = w_hit && (w_cs == col_q);

    always_comb begin
        dwell_d = w_sample ? '0 : dwell_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dwell_q   <= '0;
            state_q   <= SCAN;
            row_q     <= kpyd_row_t'(1);
            col_q     <= '0;
            kpyd_q    <= '0;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
            match_q   <= '0;
            rel_q     <= '0;
`ifdef KPYD_SCANNER_REPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            dwell_q <= dwell_d;
            if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
            if (w_sample) begin
                unique case (state_q)
                    SCAN: begin
                        // A pending event blocks new presses entirely.
                        if (!w_hit || valid_q) begin
                            row_q <= kpyd_rot_row(row_q);
                        end else begin
                            col_q   <= w_cs;
                            match_q <= MW'(1);
                            if (debounce_p == 1) begin
                                kpyd_q    <= {row_q, w_cs};
                                valid_q   <= 1'b1;
                                pressed_q <= 1'b1;
                                rel_q     <= '0;
`ifdef KPYD_SCANNER_REPEAT_EN
                                rep_q     <= '0;
`endif
                                state_q   <= HELD;
                            end else begin
                                state_q <= CONFIRM;
                            end
                        end
                    end
                    CONFIRM: begin
                        if (w_match) begin
                            if (match_q + 1'b1 == DEB_N) begin
                                kpyd_q    <= {row_q, col_q};
                                valid_q   <= 1'b1;
                                pressed_q <= 1'b1;
                                rel_q     <= '0;
`ifdef KPYD_SCANNER_REPEAT_EN
                                rep_q     <= '0;
`endif
                                state_q   <= HELD;
                            end else begin
                                match_q <= match_q + 1'b1;
                            end
                        end else begin
                            row_q   <= kpyd_rot_row(row_q);
                            state_q <= SCAN;
                        end
                    end
                    HELD: begin
                        if (w_match) begin
                            rel_q <= '0;
`ifdef KPYD_SCANNER_REPEAT_EN
                            // Repeat is dropped if the previous event is still unaccepted.
                            if (rep_q + 1'b1 == REP_N) begin
                                rep_q <= '0;
                                if (!valid_q || ready_i) begin
                                    valid_q <= 1'b1;
                                end
                            end else begin
                                rep_q <= rep_q + 1'b1;
                            end
`endif
                        end else begin
`ifdef KPYD_SCANNER_REPEAT_EN
                            rep_q <= '0;
`endif
                            if (rel_q + 1'b1 == DEB_N) begin
                                rel_q     <= '0;
                                pressed_q <= 1'b0;
                                row_q     <= kpyd_rot_row(row_q);
                                state_q   <= SCAN;
                            end else begin
                                rel_q <= rel_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= SCAN;
                    end
                endcase
            end
        end
    end

    assign row_o     = row_q;
    assign kpyd_o    = kpyd_q;
    assign valid_o   = valid_q;
    assign pressed_o = pressed_q;

endmodule

`default_nettype wire

// File: tb/tb_kpyd_scanner.sv
// ============================================================================
//  Module      : tb_kpyd_scanner
//  Description : Directed self-checking bench for kpyd_scanner with a keypad
//                matrix model and an event scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kpyd_scanner;

    logic       clk = 1'b0;
    logic       reset_i;
    logic [3:0] col_i;
    logic [3:0] row_o;
    logic [7:0] kpyd_o;
    logic       valid_o;
    logic       ready_i;
    logic       pressed_o;

    logic       key_on  = 1'b0;
    logic [3:0] key_row = 4'b0000;
    logic [3:0] key_col = 4'b0000;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc      = 0;
    int         hs_cnt   = 0;
    int         hs_cyc   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_code;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A pressed key shorts its row drive onto its column line.
    assign col_i = (key_on && (row_o == key_row)) ? key_col : 4'b0000;

    kpyd_scanner #(
        .scan_cycles_p (4),
        .debounce_p    (2),
        .repeat_p      (3)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .col_i     (col_i),
        .row_o     (row_o),
        .kpyd_o    (kpyd_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .pressed_o (pressed_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_row(input logic [3:0] r);
        int n = 0;
        while (row_o == r && n < 40) begin tick(1); n++; end
        while (row_o != r && n < 40) begin tick(1); n++; end
        chk("wait_row_timeout", 32'(n < 40), 32'd1);
    endtask

    task automatic wait_hs(input int prev, input int limit);
        int n = 0;
        while (hs_cnt == prev && n < limit) begin tick(1); n++; end
        chk("handshake_timeout", 32'(hs_cnt != prev), 32'd1);
    endtask

    always @(negedge clk) begin
        if (!reset_i && valid_o && ready_i) begin
            hs_cnt++;
            hs_cyc = cyc;
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_errors++;
                $error("FAIL unexpected_event observed %0h expected none", kpyd_o);
            end
            if (exp_q.size() != 0) begin
                exp_code = exp_q.pop_front();
                chk("event_code", 32'(kpyd_o), 32'(exp_code));
            end
        end
    end

    initial begin
        int n;
        int prev;
        int t0;

        reset_i = 1'b1;
        ready_i = 1'b0;
        tick(3);
        reset_i = 1'b0;
        chk("rst_row", 32'(row_o), 32'h1);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_kpyd", 32'(kpyd_o), 32'h00);
        chk("rst_pressed", 32'(pressed_o), 32'h0);

        tick(4); chk("scan_row1", 32'(row_o), 32'h2);
        tick(4); chk("scan_row2", 32'(row_o), 32'h4);
        tick(4); chk("scan_row3", 32'(row_o), 32'h8);
        tick(4); chk("scan_wrap", 32'(row_o), 32'h1);

        // Clean press at row 2, col 1 with exact latency.
        ready_i = 1'b1;
        wait_row(4'b0100);
        key_row = 4'b0100; key_col = 4'b0010; key_on = 1'b1;
        exp_q.push_back(8'h42);
        tick(7);
        chk("press_valid_early", 32'(valid_o), 32'h0);
        tick(1);
        chk("press_valid", 32'(valid_o), 32'h1);
        chk("press_pressed", 32'(pressed_o), 32'h1);
        chk("press_kpyd", 32'(kpyd_o), 32'h42);
        tick(1);
        chk("press_valid_drop", 32'(valid_o), 32'h0);
        key_on = 1'b0;
        n = 0;
        while (pressed_o && n < 30) begin tick(1); n++; end
        chk("release_latency", 32'(n), 32'd7);
        chk("release_row", 32'(row_o), 32'h8);

        // Single-sample bounce: row held one extra dwell, then resumes.
        wait_row(4'b0010);
        key_row = 4'b0010; key_col = 4'b0100; key_on = 1'b1;
        tick(4);
        key_on = 1'b0;
        tick(3);
        chk("bounce_row_held", 32'(row_o), 32'h2);
        tick(1);
        chk("bounce_row_next", 32'(row_o), 32'h4);
        chk("bounce_pressed", 32'(pressed_o), 32'h0);

        // Two columns at once is not a hit.
        wait_row(4'b0100);
        key_row = 4'b0100; key_col = 4'b0011; key_on = 1'b1;
        n = 0;
        while (row_o == 4'b0100 && n < 20) begin tick(1); n++; end
        chk("multi_col_dwell", 32'(n), 32'd4);
        key_on = 1'b0;
        tick(8);
        chk("multi_col_valid", 32'(valid_o), 32'h0);

        // Backpressure: first event frozen, second press lost.
        ready_i = 1'b0;
        key_row = 4'b0001; key_col = 4'b1000; key_on = 1'b1;
        exp_q.push_back(8'h18);
        n = 0;
        while (!valid_o && n < 60) begin tick(1); n++; end
        chk("bp_valid", 32'(valid_o), 32'h1);
        chk("bp_kpyd", 32'(kpyd_o), 32'h18);
        key_on = 1'b0;
        n = 0;
        while (pressed_o && n < 40) begin tick(1); n++; end
        chk("bp_release", 32'(pressed_o), 32'h0);
        chk("bp_valid_after_release", 32'(valid_o), 32'h1);
        key_row = 4'b1000; key_col = 4'b0001; key_on = 1'b1;
        tick(40);
        chk("bp_second_valid", 32'(valid_o), 32'h1);
        chk("bp_second_kpyd", 32'(kpyd_o), 32'h18);
        chk("bp_second_pressed", 32'(pressed_o), 32'h0);
        key_on = 1'b0;
        tick(8);
        prev = hs_cnt;
        ready_i = 1'b1;
        tick(1);
        chk("bp_valid_drop", 32'(valid_o), 32'h0);
        chk("bp_kpyd_kept", 32'(kpyd_o), 32'h18);
        tick(40);
        chk("bp_one_handshake", 32'(hs_cnt - prev), 32'd1);

        // Reset while in CONFIRM.
        wait_row(4'b0010);
        key_row = 4'b0010; key_col = 4'b0001; key_on = 1'b1;
        tick(5);
        chk("confirm_row_held", 32'(row_o), 32'h2);
        reset_i = 1'b1; key_on = 1'b0;
        tick(1);
        chk("rst_confirm_row", 32'(row_o), 32'h1);
        chk("rst_confirm_kpyd", 32'(kpyd_o), 32'h00);
        chk("rst_confirm_valid", 32'(valid_o), 32'h0);
        chk("rst_confirm_pressed", 32'(pressed_o), 32'h0);
        reset_i = 1'b0;

        // Reset with an event pending.
        ready_i = 1'b0;
        key_row = 4'b0100; key_col = 4'b0100; key_on = 1'b1;
        n = 0;
        while (!valid_o && n < 60) begin tick(1); n++; end
        chk("pend_kpyd", 32'(kpyd_o), 32'h44);
        key_on = 1'b0;
        reset_i = 1'b1;
        tick(1);
        chk("rst_pend_valid", 32'(valid_o), 32'h0);
        chk("rst_pend_kpyd", 32'(kpyd_o), 32'h00);
        chk("rst_pend_pressed", 32'(pressed_o), 32'h0);
        chk("rst_pend_row", 32'(row_o), 32'h1);
        exp_q.delete();
        reset_i = 1'b0;
        ready_i = 1'b1;
        tick(2);

        // Long hold: repeats every three dwells only when enabled.
        prev = hs_cnt;
        key_row = 4'b1000; key_col = 4'b1000; key_on = 1'b1;
        exp_q.push_back(8'h88);
        wait_hs(prev, 60);
        t0 = hs_cyc;
`ifdef KPYD_SCANNER_REPEAT_EN
        exp_q.push_back(8'h88);
        prev = hs_cnt;
        wait_hs(prev, 30);
        chk("repeat_interval1", 32'(hs_cyc - t0), 32'd12);
        t0 = hs_cyc;
        exp_q.push_back(8'h88);
        prev = hs_cnt;
        wait_hs(prev, 30);
        chk("repeat_interval2", 32'(hs_cyc - t0), 32'd12);
        key_on = 1'b0;
        tick(40);
`else
        tick(60);
        key_on = 1'b0;
        tick(40);
        chk("hold_single_event", 32'(hs_cnt - prev), 32'd1);
`endif
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
